// File: rtl/sseg_display_driver_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sseg_display_driver_pkg
// Description : Shared constants for the 7-segment display driver: glyph
//               table (active-high), blank/dash codes and digit count.
// Revision    : 1.0 - initial release
// ============================================================================
package sseg_display_driver_pkg;

    localparam int c_NUM_DIGITS = 8;
    localparam int c_IDX_W      = $clog2(c_NUM_DIGITS);

    // Output-level (active-low) codes: all segments off, and segment g only lit.
    localparam logic [6:0] c_SEG_BLANK = 7'h7F;
    localparam logic [6:0] c_SEG_DASH  = 7'h3F;

    // Active-high glyphs for 0-9, A b C d E F; entry [n] is the glyph of nibble n.
    localparam logic [15:0][6:0] c_SEG_PATTERNS = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage : sseg_display_driver_pkg
`default_nettype wire

// File: rtl/sseg_display_driver_hex_to_sseg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_sseg
// Description : Combinational hex nibble to active-low 7-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_sseg
    import sseg_display_driver_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    // Table lookup, inverted for the common-anode board.
    assign o_seg = ~c_SEG_PATTERNS[i_nibble];

endmodule : hex_to_sseg
`default_nettype wire

// File: rtl/sseg_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : sseg_display_driver
// Description : Time-multiplexed 8-digit hex display driver with per-frame
//               value latching, leading-zero blanking and empty/full marks.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_display_driver
    import sseg_display_driver_pkg::*;
#(
    parameter int PRESCALE = 100000,
    parameter int CNT_W    = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             value,
    input  logic                    empty,
    input  logic                    full,
    input  logic                    blank_lz,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [c_NUM_DIGITS-1:0] an
);

    logic [CNT_W-1:0]        r_cnt;
    logic [c_IDX_W-1:0]      r_idx;
    logic [31:0]             r_shadow_value;
    logic                    r_shadow_empty;
    logic                    r_shadow_full;
    logic                    r_shadow_blank_lz;
    logic                    r_shadow_valid;

    logic                    w_cnt_wrap;
    logic                    w_last_digit;
    logic                    w_frame_wrap;
    logic [4:0]              w_bit_pos;
    logic [3:0]              w_nibble;
    logic [6:0]              w_hex_seg;
    logic                    w_upper_zero;
    logic [6:0]              w_seg_next;
    logic                    w_dp_next;
    logic [c_NUM_DIGITS-1:0] w_an_next;

    assign w_cnt_wrap   = (r_cnt == CNT_W'(PRESCALE - 1));
    assign w_last_digit = (r_idx == c_IDX_W'(c_NUM_DIGITS - 1));
    assign w_frame_wrap = w_cnt_wrap && w_last_digit;

    // Prescaler and digit index: each digit stays lit for PRESCALE cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_idx <= '0;
        end else if (w_cnt_wrap) begin
            r_cnt <= '0;
            r_idx <= r_idx + c_IDX_W'(1);
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Frame capture on the 7->0 wrap so a frame never mixes two values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shadow_value    <= '0;
            r_shadow_empty    <= 1'b0;
            r_shadow_full     <= 1'b0;
            r_shadow_blank_lz <= 1'b0;
            r_shadow_valid    <= 1'b0;
        end else if (w_frame_wrap) begin
            r_shadow_value    <= value;
            r_shadow_empty    <= empty;
            r_shadow_full     <= full;
            r_shadow_blank_lz <= blank_lz;
            r_shadow_valid    <= 1'b1;
        end
    end

    assign w_bit_pos    = {r_idx, 2'b00};
    assign w_nibble     = r_shadow_value[w_bit_pos +: 4];
    // True when this digit and every digit to its left are zero.
    assign w_upper_zero = ((r_shadow_value >> w_bit_pos) == 32'd0);

    hex_to_sseg u_hex_to_sseg (
        .i_nibble (w_nibble),
        .o_seg    (w_hex_seg)
    );

    // Per-digit rendering: empty overrides value, then leading-zero blanking.
    always_comb begin
        w_seg_next = c_SEG_BLANK;
        w_dp_next  = 1'b1;
        w_an_next  = '1;
        if (r_shadow_valid) begin
            w_an_next = ~(c_NUM_DIGITS'(1) << r_idx);
            if (r_shadow_empty) begin
                w_seg_next = (r_idx == '0) ? c_SEG_DASH : c_SEG_BLANK;
            end else if (r_shadow_blank_lz && (r_idx != '0) && w_upper_zero) begin
                w_seg_next = c_SEG_BLANK;
            end else begin
                w_seg_next = w_hex_seg;
            end
            w_dp_next = ~(r_shadow_full && w_last_digit);
        end
    end

    // Registered outputs, one cycle behind the digit index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            seg <= c_SEG_BLANK;
            dp  <= 1'b1;
            an  <= '1;
        end else begin
            seg <= w_seg_next;
            dp  <= w_dp_next;
            an  <= w_an_next;
        end
    end

endmodule : sseg_display_driver
`default_nettype wire

// File: tb/tb_sseg_display_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_sseg_display_driver
// Description : Self-checking bench for sseg_display_driver (PRESCALE = 4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_display_driver;

    localparam int P     = 4;
    localparam int FRAME = 8 * P;
    localparam int DEPTH = 4096;

    logic        clk;
    logic        rst;
    logic [31:0] value;
    logic        empty;
    logic        full;
    logic        blank_lz;
    logic [6:0]  seg;
    logic        dp;
    logic [7:0]  an;

    int total;
    int bad;
    int k;

    // Inputs seen at each clock edge since the last reset release.
    logic [31:0] h_val [DEPTH];
    logic        h_emp [DEPTH];
    logic        h_full[DEPTH];
    logic        h_blz [DEPTH];

    // Active-high glyphs 0..F.
    logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        logic [31:0]     val;
        logic            emp;
        logic            fl;
        logic            blz;
        logic [7:0][6:0] exp_seg;  // [d] = expected seg on digit d
        logic            exp_dp7;
    } vec_t;

    vec_t vecs[8];

    sseg_display_driver #(
        .PRESCALE (P),
        .CNT_W    (3)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .value    (value),
        .empty    (empty),
        .full     (full),
        .blank_lz (blank_lz),
        .seg      (seg),
        .dp       (dp),
        .an       (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (k=%0d)", name, act, exp, k);
        end
    endtask

    // Expected outputs after edge n: they reflect the state after edge n-1.
    // The index is ((n-1)/P)%8; the frame was captured at the last multiple of FRAME.
    task automatic model(input int n, output logic [7:0] ean, output logic [6:0] eseg, output logic edp);
        int j, f, d;
        logic [31:0] v;
        j = n - 1;
        ean = 8'hFF; eseg = 7'h7F; edp = 1'b1;
        if (j >= FRAME) begin
            f = (j / FRAME) * FRAME;
            d = (j / P) % 8;
            v = h_val[f];
            ean = ~(8'd1 << d);
            if (h_emp[f])
                eseg = (d == 0) ? 7'h3F : 7'h7F;
            else if (h_blz[f] && d != 0 && (v >> (4 * d)) == 0)
                eseg = 7'h7F;
            else
                eseg = ~glyph[(v >> (4 * d)) & 32'hF];
            edp = !(h_full[f] && d == 7);
        end
    endtask

    // One clock: record the inputs at the edge, then check against the model.
    task automatic step();
        logic [7:0] ean;
        logic [6:0] eseg;
        logic       edp;
        @(posedge clk);
        k++;
        if (k < DEPTH) begin
            h_val[k] = value; h_emp[k] = empty; h_full[k] = full; h_blz[k] = blank_lz;
            @(negedge clk);
            model(k, ean, eseg, edp);
            chk("model_an", 32'(an), 32'(ean));
            chk("model_seg", 32'(seg), 32'(eseg));
            chk("model_dp", 32'(dp), 32'(edp));
        end else begin
            @(negedge clk);
            chk("history_depth", k, DEPTH - 1);
        end
    endtask

    initial begin
        logic [7:0][6:0] obs_seg;
        logic [7:0]      obs_dp;
        logic [7:0]      seen;
        int              first_fe;
        bit              found;

        total = 0; bad = 0; k = 0;
        vecs[0] = '{32'h1234ABCD, 1'b0, 1'b0, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21}, 1'b1};
        vecs[1] = '{32'h000000A0, 1'b0, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h08, 7'h40}, 1'b1};
        vecs[2] = '{32'h00000000, 1'b0, 1'b0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b1};
        vecs[3] = '{32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F}, 1'b1};
        vecs[4] = '{32'h1234ABCD, 1'b0, 1'b1, 1'b0, {7'h79, 7'h24, 7'h30, 7'h19, 7'h08, 7'h03, 7'h46, 7'h21}, 1'b0};
        vecs[5] = '{32'h00000000, 1'b1, 1'b1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h3F}, 1'b0};
        vecs[6] = '{32'h00000000, 1'b0, 1'b0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b1};
        vecs[7] = '{32'h0F000000, 1'b0, 1'b0, 1'b1, {7'h7F, 7'h0E, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}, 1'b1};

        value = 32'h1234ABCD; empty = 1'b0; full = 1'b0; blank_lz = 1'b0;

        // Reset held for 10 cycles: outputs idle throughout.
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("rst_an", 32'(an), 32'hFF);
            chk("rst_seg", 32'(seg), 32'h7F);
            chk("rst_dp", 32'(dp), 32'h1);
        end
        rst = 1'b1;
        k = 0;

        // Blank until the first capture, then digit 0 one cycle after the wrap.
        first_fe = -1;
        for (int i = 0; i < FRAME + 4; i++) begin
            step();
            if (first_fe < 0 && an != 8'hFF) first_fe = k;
        end
        chk("first_digit_edge", first_fe, FRAME + 1);

        // Table vectors: hold inputs two frames, then observe a full frame.
        for (int v = 0; v < 8; v++) begin
            value = vecs[v].val; empty = vecs[v].emp; full = vecs[v].fl; blank_lz = vecs[v].blz;
            for (int i = 0; i < 2 * FRAME; i++) step();
            seen = '0; obs_seg = '0; obs_dp = '0;
            for (int i = 0; i < FRAME; i++) begin
                step();
                for (int d = 0; d < 8; d++) begin
                    if (an == ~(8'd1 << d)) begin
                        seen[d] = 1'b1; obs_seg[d] = seg; obs_dp[d] = dp;
                    end
                end
            end
            chk($sformatf("vec%0d_slots", v), 32'(seen), 32'hFF);
            for (int d = 0; d < 8; d++) begin
                chk($sformatf("vec%0d_seg_d%0d", v, d), 32'(obs_seg[d]), 32'(vecs[v].exp_seg[d]));
                chk($sformatf("vec%0d_dp_d%0d", v, d), 32'(obs_dp[d]), (d == 7) ? 32'(vecs[v].exp_dp7) : 32'h1);
            end
        end

        // Anti-tear: change value while digit 3 is lit.
        value = 32'h11111111; empty = 1'b0; full = 1'b0; blank_lz = 1'b0;
        step();
        while (k % FRAME != 0) step();
        for (int i = 0; i < 3 * P; i++) step();
        value = 32'h22222222;
        for (int i = 0; i < 5 * P; i++) begin
            step();
            chk("tear_old_frame", 32'(seg), 32'h79);
        end
        for (int i = 0; i < FRAME; i++) begin
            step();
            chk("tear_new_frame", 32'(seg), 32'h24);
        end

        // Randomized inputs, checked each cycle by the model.
        for (int i = 0; i < 20 * FRAME; i++) begin
            if ($urandom_range(3) == 0) begin
                value    = $urandom() >> (4 * $urandom_range(7));
                empty    = ($urandom_range(7) == 0);
                full     = ($urandom_range(3) == 0);
                blank_lz = $urandom_range(1) == 1;
            end
            step();
        end

        // Asynchronous reset during the digit-5 slot.
        value = 32'h1234ABCD; empty = 1'b0; full = 1'b1; blank_lz = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 3 * FRAME && !found; i++) begin
            step();
            if (an == 8'hDF) found = 1'b1;
        end
        chk("reach_digit5", 32'(found), 32'h1);
        #1 rst = 1'b0;
        #1;
        chk("async_rst_an", 32'(an), 32'hFF);
        chk("async_rst_seg", 32'(seg), 32'h7F);
        chk("async_rst_dp", 32'(dp), 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("held_rst_an", 32'(an), 32'hFF);
        rst = 1'b1;
        k = 0;
        for (int i = 0; i < 2 * FRAME + 4; i++) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_sseg_display_driver
`default_nettype wire
